// File: rtl/number_analyzer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | number_analyzer_pkg                                                      |
// | Mode encodings and FSM state type shared by the number_analyzer block.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package number_analyzer_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_EVEN  = 2'd0;
  localparam logic [MODE_W-1:0] MODE_ODD   = 2'd1;
  localparam logic [MODE_W-1:0] MODE_POW2  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_DIVBY = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/num_remainder_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | num_remainder_serial                                                     |
// | Serial restoring remainder, MSB first, one dividend bit per cycle.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module num_remainder_serial
  import number_analyzer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] number_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH:0]   rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] w_idx;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_step;
  logic             w_unused_rem_msb;

  // number_i and divisor_i are held stable by the caller for the whole run.
  assign w_idx   = LAST - cnt_q;
  assign w_trial = {rem_q[WIDTH-1:0], number_i[w_idx]};
  assign w_step  = (w_trial >= {1'b0, divisor_i}) ? (w_trial - {1'b0, divisor_i}) : w_trial;

  // The partial remainder is always below the divisor, so its MSB stays clear.
  assign w_unused_rem_msb = rem_q[WIDTH];

  always_comb begin
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      rem_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = w_step;
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // done_o flags the final step; remainder_o carries that step's result.
  assign busy_o      = busy_q;
  assign done_o      = busy_q && (cnt_q == LAST);
  assign remainder_o = w_step[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/number_analyzer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | number_analyzer                                                          |
// | Classifies an operand as even/odd/power-of-two or divisible by divisor.  |
// | DIVBY datapath present only when NUMBER_ANALYZER_DIVBY_EN is defined.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module number_analyzer
  import number_analyzer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go_i,
  input  logic [WIDTH-1:0]  number,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [WIDTH-1:0]  divisor_i,
  output logic              result,
  output logic [WIDTH-1:0]  remainder_o,
  output logic              error_o,
  output logic              done_o,
  output logic              busy_o
);

  state_e           state_q, state_d;
  logic             result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic             w_pow2;

  assign w_pow2 = (number != '0) && ((number & (number - WIDTH'(1))) == '0);

`ifdef NUMBER_ANALYZER_DIVBY_EN
  logic [WIDTH-1:0] number_q, number_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             w_div_start;
  logic             w_div_busy;
  logic             w_div_done;
  logic [WIDTH-1:0] w_div_rem;
  logic             w_unused_div_busy;

  assign w_unused_div_busy = w_div_busy;

  num_remainder_serial #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .start_i     (w_div_start),
    .number_i    (number_q),
    .divisor_i   (divisor_q),
    .busy_o      (w_div_busy),
    .done_o      (w_div_done),
    .remainder_o (w_div_rem)
  );
`else
  logic w_unused_divisor;

  assign w_unused_divisor = ^divisor_i;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rem_d    = rem_q;
    err_d    = err_q;
`ifdef NUMBER_ANALYZER_DIVBY_EN
    number_d    = number_q;
    divisor_d   = divisor_q;
    w_div_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (go_i) begin
          state_d  = ST_DONE;
          result_d = 1'b0;
          rem_d    = '0;
          err_d    = 1'b0;
`ifdef NUMBER_ANALYZER_DIVBY_EN
          number_d  = number;
          divisor_d = divisor_i;
`endif
          case (mode_i)
            MODE_EVEN: result_d = ~number[0];
            MODE_ODD:  result_d = number[0];
            MODE_POW2: result_d = w_pow2;
            MODE_DIVBY: begin
`ifdef NUMBER_ANALYZER_DIVBY_EN
              // A zero divisor is reported immediately instead of running.
              if (divisor_i == '0) begin
                err_d = 1'b1;
              end else begin
                w_div_start = 1'b1;
                state_d     = ST_RUN;
              end
`else
              err_d = 1'b1;
`endif
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_RUN: begin
`ifdef NUMBER_ANALYZER_DIVBY_EN
        if (w_div_done) begin
          state_d  = ST_DONE;
          result_d = (w_div_rem == '0);
          rem_d    = w_div_rem;
          err_d    = 1'b0;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= 1'b0;
      rem_q    <= '0;
      err_q    <= 1'b0;
`ifdef NUMBER_ANALYZER_DIVBY_EN
      number_q  <= '0;
      divisor_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
`ifdef NUMBER_ANALYZER_DIVBY_EN
      number_q  <= number_d;
      divisor_q <= divisor_d;
`endif
    end
  end

  assign result      = result_q;
  assign remainder_o = rem_q;
  assign error_o     = err_q;
  assign done_o      = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
